// File: rtl/time_tmr_replay_buffer_pkg.sv
// Shared definitions for the time-redundant replay buffer and the end stage
// that feeds retirement reports back to it.
package time_tmr_replay_buffer_pkg;

  localparam int unsigned MaxIdSize = 16;

  typedef struct packed {
    logic                 valid;
    logic [MaxIdSize-1:0] id;
    logic                 fault;
  } retire_rpt_t;

  function automatic logic rpt_matches(retire_rpt_t rpt, logic [MaxIdSize-1:0] slot);
    return rpt.valid && (rpt.id == slot);
  endfunction

endpackage

// File: rtl/time_tmr_replay_ptr.sv
// Wrap-bit pointer: MSB distinguishes full from empty, load overrides increment.
module time_tmr_replay_ptr #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic [Width-1:0] value
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= value + Width'(1);
    end
  end

endmodule

// File: rtl/time_tmr_replay_buffer.sv
// Circular replay buffer: holds accepted items until retired and rewinds the
// issue pointer on an uncorrectable fault for in-order, at-least-once delivery.
module time_tmr_replay_buffer
  import time_tmr_replay_buffer_pkg::*;
#(
  parameter type         DataType   = logic,
  parameter int unsigned Depth      = 8,
  parameter int unsigned IDSize     = $clog2(Depth),
  parameter int unsigned MaxReplays = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              retire_valid_i,
  input  logic [IDSize-1:0] retire_id_i,
  input  logic              retire_fault_i,
  output logic              flush_o,
  output logic              unrecoverable_o,
  output logic              seq_error_o
);

  localparam int unsigned PtrW = IDSize + 1;
  localparam int unsigned FcW  = (MaxReplays > 1) ? $clog2(MaxReplays) : 1;

  logic [PtrW-1:0] wr_ptr, iss_ptr, ret_ptr;
  logic [FcW-1:0]  fault_cnt;
  logic            flush_q, unrec_q, seq_err_q;
  DataType         mem [Depth];

  logic full, pending, inflight, accept, issue;
  logic ret_ok, ret_advance, rewind, force_retire, seq_err;
  retire_rpt_t rpt;

  assign full     = (wr_ptr - ret_ptr) == PtrW'(Depth);
  assign pending  = iss_ptr != wr_ptr;
  assign inflight = iss_ptr != ret_ptr;

  assign ready_o = ~full;
  assign valid_o = pending & ~flush_q;
  assign data_o  = mem[iss_ptr[IDSize-1:0]];
  assign id_o    = iss_ptr[IDSize-1:0];

  assign accept = valid_i & ready_o;
  assign issue  = valid_o & ready_i;

  assign rpt = '{valid: retire_valid_i, id: MaxIdSize'(retire_id_i), fault: retire_fault_i};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ret_ok       = 1'b0;
    rewind       = 1'b0;
    force_retire = 1'b0;
    ret_advance  = 1'b0;
    seq_err      = 1'b0;
    if (rpt_matches(rpt, MaxIdSize'(ret_ptr[IDSize-1:0])) && inflight && !flush_q) begin
      ret_ok = 1'b1;
    end
    if (ret_ok) begin
      if (rpt.fault && fault_cnt != FcW'(MaxReplays - 1)) begin
        rewind = 1'b1;
      end else begin
        force_retire = rpt.fault;
        ret_advance  = 1'b1;
      end
    end else begin
      seq_err = rpt.valid;
    end
  end

  time_tmr_replay_ptr #(.Width(PtrW)) u_wr_ptr (
    .clk(clk_i), .rst(rst_i), .inc(accept), .load(1'b0), .load_val('0), .value(wr_ptr)
  );

  // A rewind outranks a same-cycle issue; the issued item simply gets replayed.
  time_tmr_replay_ptr #(.Width(PtrW)) u_iss_ptr (
    .clk(clk_i), .rst(rst_i), .inc(issue), .load(rewind), .load_val(ret_ptr), .value(iss_ptr)
  );

  time_tmr_replay_ptr #(.Width(PtrW)) u_ret_ptr (
    .clk(clk_i), .rst(rst_i), .inc(ret_advance), .load(1'b0), .load_val('0), .value(ret_ptr)
  );

  // NOTE: payload storage has no reset; only the pointers decide which slots are meaningful.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem[wr_ptr[IDSize-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fault_cnt <= '0;
      flush_q   <= 1'b0;
      unrec_q   <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      flush_q   <= rewind;
      unrec_q   <= force_retire;
      seq_err_q <= seq_err;
      if (ret_advance) begin
        fault_cnt <= '0;
      end else if (rewind) begin
        fault_cnt <= fault_cnt + FcW'(1);
      end
    end
  end

  assign flush_o         = flush_q;
  assign unrecoverable_o = unrec_q;
  assign seq_error_o     = seq_err_q;

endmodule

// File: tb/tb_time_tmr_replay_buffer.sv
// Self-checking bench: queue-based reference model plus directed scenarios
// and a randomized stream with faults and stray retirements.
module tb_time_tmr_replay_buffer;

  localparam int DEPTH       = 8;
  localparam int ID_W        = 3;
  localparam int MAX_REPLAYS = 3;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [15:0]     data_i;
  logic            valid_i;
  logic            ready_o;
  logic [15:0]     data_o;
  logic [ID_W-1:0] id_o;
  logic            valid_o;
  logic            ready_i;
  logic            retire_valid_i;
  logic [ID_W-1:0] retire_id_i;
  logic            retire_fault_i;
  logic            flush_o;
  logic            unrecoverable_o;
  logic            seq_error_o;

  time_tmr_replay_buffer #(
    .DataType(logic [15:0]), .Depth(DEPTH), .MaxReplays(MAX_REPLAYS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .id_o(id_o), .valid_o(valid_o), .ready_i(ready_i),
    .retire_valid_i(retire_valid_i), .retire_id_i(retire_id_i),
    .retire_fault_i(retire_fault_i), .flush_o(flush_o),
    .unrecoverable_o(unrecoverable_o), .seq_error_o(seq_error_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: unretired payloads in a queue, plus counts.
  logic [15:0] m_buf[$];
  int m_nis;      // items issued but not yet retired
  int m_ret_seq;  // total retirements since reset
  int m_fcnt;
  bit m_flush, m_unrec, m_seq;
  int m_acc_cnt;

  function automatic void model_reset();
    m_buf.delete();
    m_nis = 0; m_ret_seq = 0; m_fcnt = 0;
    m_flush = 0; m_unrec = 0; m_seq = 0;
  endfunction

  function automatic bit exp_ready();
    return m_buf.size() < DEPTH;
  endfunction

  function automatic bit exp_valid();
    return (m_nis < m_buf.size()) && !m_flush;
  endfunction

  function automatic int exp_id();
    return (m_ret_seq + m_nis) % DEPTH;
  endfunction

  function automatic void model_step();
    bit acc, iss, ok;
    int n;
    acc = valid_i && exp_ready();
    iss = exp_valid() && ready_i;
    ok  = retire_valid_i && (m_nis > 0) && !m_flush &&
          (int'(retire_id_i) == m_ret_seq % DEPTH);
    n = m_nis + (iss ? 1 : 0);
    m_seq   = retire_valid_i && !ok;
    m_flush = 0;
    m_unrec = 0;
    if (ok) begin
      if (retire_fault_i && m_fcnt < MAX_REPLAYS - 1) begin
        m_fcnt++;
        n = 0;
        m_flush = 1;
      end else begin
        m_unrec = retire_fault_i;
        m_fcnt  = 0;
        void'(m_buf.pop_front());
        n--;
        m_ret_seq++;
      end
    end
    if (acc) begin
      m_buf.push_back(data_i);
      m_acc_cnt++;
    end
    m_nis = n;
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk_i) begin
    check("ready_o", 32'(ready_o), 32'(exp_ready()));
    check("valid_o", 32'(valid_o), 32'(exp_valid()));
    check("id_o", 32'(id_o), 32'(exp_id()));
    if (exp_valid()) check("data_o", 32'(data_o), 32'(m_buf[m_nis]));
    check("flush_o", 32'(flush_o), 32'(m_flush));
    check("unrecoverable_o", 32'(unrecoverable_o), 32'(m_unrec));
    check("seq_error_o", 32'(seq_error_o), 32'(m_seq));
  end

  // One clock: model follows the edge, returns 1 time unit after it.
  task automatic cyc();
    @(posedge clk_i);
    if (rst_i) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 0; ready_i = 0; retire_valid_i = 0; retire_fault_i = 0;
    retire_id_i = '0; data_i = '0;
  endtask

  // Asynchronous reset between edges; must be called right after cyc().
  task automatic do_reset();
    #1;
    rst_i = 1;
    model_reset();
    idle_inputs();
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_id", 32'(id_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 0;
  endtask

  task automatic retire(int id, bit fault);
    retire_valid_i = 1; retire_id_i = ID_W'(id); retire_fault_i = fault;
    cyc();
    retire_valid_i = 0; retire_fault_i = 0;
  endtask

  initial begin
    int cycles;
    rst_i = 1;
    idle_inputs();
    model_reset();
    m_acc_cnt = 0;
    @(posedge clk_i);
    #1;
    rst_i = 0;

    // Fill then drain, no faults.
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("fill_ready_before_last", 32'(ready_o), 32'd1);
      valid_i = 1; data_i = 16'hA000 + 16'(i);
      cyc();
    end
    valid_i = 0;
    check("fill_full_ready", 32'(ready_o), 32'd0);
    ready_i = 1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_data", 32'(data_o), 32'hA000 + 32'(i));
      check("drain_id", 32'(id_o), 32'(i));
      cyc();
    end
    ready_i = 0;
    for (int i = 0; i < DEPTH; i++) retire(i, 0);
    check("drain_ready", 32'(ready_o), 32'd1);
    check("drain_valid", 32'(valid_o), 32'd0);

    // Single fault on ID 1 with IDs 0..3 in flight.
    for (int i = 0; i < 4; i++) begin
      valid_i = 1; data_i = 16'hB000 + 16'(i);
      cyc();
    end
    valid_i = 0; ready_i = 1;
    repeat (4) cyc();
    ready_i = 0;
    retire(0, 0);
    retire(1, 1);
    check("fault_flush", 32'(flush_o), 32'd1);
    check("fault_valid_blocked", 32'(valid_o), 32'd0);
    ready_i = 1;
    cyc();
    for (int i = 1; i < 4; i++) begin
      check("replay_valid", 32'(valid_o), 32'd1);
      check("replay_id", 32'(id_o), 32'(i));
      check("replay_data", 32'(data_o), 32'hB000 + 32'(i));
      cyc();
    end
    ready_i = 0;
    for (int i = 1; i < 4; i++) retire(i, 0);
    check("replay_seqerr", 32'(seq_error_o), 32'd0);

    // Three consecutive faults on ID 0: two flushes, then force-retire.
    do_reset();
    ready_i = 1; valid_i = 1; data_i = 16'hC000;
    cyc();
    valid_i = 0;
    cyc();
    for (int f = 0; f < MAX_REPLAYS; f++) begin
      retire(0, 1);
      if (f < MAX_REPLAYS - 1) begin
        check("maxrep_flush", 32'(flush_o), 32'd1);
        check("maxrep_no_unrec", 32'(unrecoverable_o), 32'd0);
        cyc();
        cyc();
      end else begin
        check("maxrep_unrec", 32'(unrecoverable_o), 32'd1);
        check("maxrep_no_flush", 32'(flush_o), 32'd0);
      end
    end
    check("maxrep_next_id", 32'(id_o), 32'd1);
    check("maxrep_empty", 32'(valid_o), 32'd0);
    ready_i = 0;

    // Wrong-ID retirement leaves state untouched.
    do_reset();
    ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1; data_i = 16'hD000 + 16'(i);
      cyc();
    end
    valid_i = 0;
    cyc();
    ready_i = 0;
    retire(2, 0);
    check("wrong_id_seqerr", 32'(seq_error_o), 32'd1);
    retire(0, 0);
    check("right_id_after_wrong", 32'(seq_error_o), 32'd0);

    // Reset with five items in flight.
    do_reset();
    ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      valid_i = 1; data_i = 16'hE000 + 16'(i);
      cyc();
    end
    valid_i = 0;
    cyc();
    do_reset();
    valid_i = 1; data_i = 16'hF00D;
    cyc();
    valid_i = 0;
    check("post_rst_valid", 32'(valid_o), 32'd1);
    check("post_rst_id", 32'(id_o), 32'd0);
    check("post_rst_data", 32'(data_o), 32'hF00D);
    ready_i = 1;
    cyc();
    ready_i = 0;
    retire(0, 0);

    // Randomized stream with occasional faults and stray retirements.
    m_acc_cnt = 0;
    cycles = 0;
    while (m_acc_cnt < 120 && cycles < 3000) begin
      int r;
      valid_i = ($urandom_range(0, 9) < 7);
      data_i  = 16'($urandom);
      ready_i = ($urandom_range(0, 3) != 0);
      retire_valid_i = 0; retire_fault_i = 0; retire_id_i = '0;
      if (m_nis > 0 && !m_flush && $urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 19);
        retire_valid_i = 1;
        retire_id_i    = ID_W'((m_ret_seq + (r == 0 ? 1 : 0)) % DEPTH);
        retire_fault_i = (r == 1 || r == 2);
      end else if ($urandom_range(0, 29) == 0) begin
        retire_valid_i = 1;
        retire_id_i    = ID_W'($urandom_range(0, DEPTH - 1));
      end
      cyc();
      cycles++;
    end
    check("stream_progress", 32'(m_acc_cnt >= 120), 32'd1);

    // Drain what is left with clean retirements.
    valid_i = 0;
    cycles = 0;
    while (m_buf.size() > 0 && cycles < 300) begin
      ready_i = 1;
      retire_fault_i = 0;
      retire_valid_i = (m_nis > 0) && !m_flush;
      retire_id_i    = ID_W'(m_ret_seq % DEPTH);
      cyc();
      cycles++;
    end
    idle_inputs();
    cyc();
    check("final_ready", 32'(ready_o), 32'd1);
    check("final_valid", 32'(valid_o), 32'd0);

    @(negedge clk_i);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/time_tmr_replay_buffer.md
# time_tmr_replay_buffer

Circular replay buffer in front of the time-redundant start stage. It holds every accepted transaction under a slot ID until the time-redundant end stage retires it. On a reported uncorrectable fault it rewinds and re-issues from the faulted transaction onward, giving at-least-once, in-order delivery. It sits between the producer and the time-redundant start stage; retirement information is fed back from the end stage.

## Interface
Parameters:
- DataType, logic, payload type stored per entry
- Depth, 8, number of slots; power of two, ≥ 2
- IDSize, $clog2(Depth), width of slot ID
- MaxReplays, 3, consecutive faults on one entry before it is force-retired

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high; clears all state
- data_i  in  DataType  upstream payload
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready (slot free)
- data_o  out  DataType  payload at issue pointer
- id_o  out  IDSize  slot ID of data_o
- valid_o  out  1  issue valid
- ready_i  in  1  downstream ready
- retire_valid_i  in  1  end stage reports a result
- retire_id_i  in  IDSize  ID of the reported result
- retire_fault_i  in  1  result was uncorrectable; request replay
- flush_o  out  1  one-cycle pulse; downstream drops all in-flight items
- unrecoverable_o  out  1  one-cycle pulse; entry force-retired after MaxReplays faults
- seq_error_o  out  1  one-cycle pulse; retirement ignored (wrong ID, nothing in flight, or during flush)

## Operation
- Pointers: wr_ptr, iss_ptr, ret_ptr; each is IDSize+1 bits, with the MSB as wrap bit. Slot index is the low IDSize bits.
- Derived conditions:
  - full = (wr_ptr − ret_ptr) == Depth
  - pending = iss_ptr != wr_ptr
  - inflight = iss_ptr != ret_ptr
- Accept: valid_i & ready_o writes mem[wr_ptr] and increments wr_ptr. ready_o = ~full.
- Issue: valid_o = pending & ~flush_q. data_o = mem[iss_ptr], id_o = iss_ptr[IDSize-1:0]. valid_o & ready_i increments iss_ptr.
- Retire: accepted only when retire_valid_i & inflight & ~flush_q & retire_id_i == ret_ptr[IDSize-1:0]. Any other retire_valid_i pulses seq_error_o and changes no state.
  - No fault: ret_ptr increments; fault_cnt clears.
  - Fault with fault_cnt < MaxReplays−1: iss_ptr ← ret_ptr; fault_cnt increments; flush_o pulses.
  - Fault with fault_cnt == MaxReplays−1: treated as retirement (ret_ptr increments); fault_cnt clears; unrecoverable_o pulses; no flush.
- flush_q: register set by a rewind. It is high for exactly the cycle after the rewind; during that cycle, issue and retirement are blocked.
- Simultaneous events:
  - Accept and retire in the same cycle are independent; both apply.
  - Issue handshake and fault rewind in the same cycle: rewind wins; iss_ptr ← ret_ptr, and the issued item is replayed later.
  - Accept when full is impossible (ready_o low). A retire in that cycle frees a slot, but ready_o rises only the next cycle.
- Pointer arithmetic is modulo 2·Depth; the wrap bit distinguishes full from empty.
- Reset (asynchronous, any time): all pointers 0, fault_cnt 0, flush_q 0. Memory is not reset. Outputs after reset:
  - ready_o = 1
  - valid_o = 0
  - id_o = 0
  - flush_o, unrecoverable_o, seq_error_o = 0
  - data_o = don't care

## Timing
- ready_o and valid_o depend only on registered state; there is no combinational path from ready_i or valid_i.
- Write-to-issue latency: 1 cycle. An item accepted in cycle N gives valid_o in N+1 if the buffer was empty.
- Retire-to-ready latency: 1 cycle.
- Rewind: flush_o is high in cycle N+1 after a fault retirement in cycle N. The replayed item appears on valid_o in cycle N+2.
- Throughput with no faults: 1 accept and 1 issue per cycle.
- flush_o, unrecoverable_o and seq_error_o are registered pulses.

## Structure
- Shared package: a retire-report typedef (valid, id, fault) so the end stage and this block agree on the feedback format.
- One sub-module: time_tmr_replay_ptr, a wrap-bit pointer with increment and load, instantiated three times.
- Memory is a plain register array inside the top module.

## Test plan
- Fill/drain, no faults, Depth=8: push 8 items with ready_i=0 → ready_o=0 after the 8th; set ready_i=1 and retire IDs 0..7 in order → data out in order, ready_o returns 1, no pulses.
- Single fault: issue IDs 0–3, then retire ID 1 with fault → flush_o in the next cycle; IDs 1,2,3 re-issued starting 2 cycles after the fault; final retirements of 0–3 succeed.
- MaxReplays=3: fault ID 0 three consecutive times → two flushes, then unrecoverable_o on the third; ret_ptr advances to 1.
- Wrong-ID retire: retire ID 2 while ret_ptr=0 → seq_error_o pulse; pointers unchanged.
- Wrap-around: stream 100 items with random ready_i and immediate retirement → IDs cycle 0..7, payload order preserved, no errors.
- Reset mid-operation: assert rst_i with 5 items in flight → the next cycle shows ready_o=1, valid_o=0; the next accepted item has ID 0.
